// File: rtl/cpu_host_mbox.sv
// CPU/host mailbox: a TX FIFO (CPU to host) and an RX FIFO (host to CPU), each with a
// control/status register and sticky error flags.
module cpu_host_mbox #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_reg,
  input  logic        rd_reg,
  input  logic [10:0] op_sel,
  input  logic [15:0] tos,
  output logic [15:0] par,
  output logic        h_rd_valid,
  output logic [15:0] h_rd_data,
  input  logic        h_rd_ready,
  input  logic        h_wr_valid,
  input  logic [15:0] h_wr_data,
  output logic        h_wr_ready,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 16;

  logic [DW-1:0] tx_mem [DEPTH];
  logic [DW-1:0] rx_mem [DEPTH];

  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW-1:0] tx_wp_nxt, tx_rp_nxt, rx_wp_nxt, rx_rp_nxt;
  logic [CW-1:0] tx_count, rx_count, tx_count_nxt, rx_count_nxt;
  logic          tx_ovf, rx_unf, tx_ovf_nxt, rx_unf_nxt;

  logic tx_push_req, ctl_wr, tx_flush, rx_flush, flag_clr;
  logic tx_full, rx_empty, h_pop, tx_push, cpu_pop_req, rx_pop, h_push;
  logic tx_ovf_set, rx_unf_set;
  logic [DW-1:0] status;
  logic unused_bits;

  assign unused_bits = ^{op_sel[10:2], tos[15:3]};

  // Decode CPU strobes and FIFO handshakes
  assign tx_push_req = wr_reg & op_sel[0];
  assign ctl_wr      = wr_reg & op_sel[1];
  assign tx_flush    = ctl_wr & tos[0];
  assign rx_flush    = ctl_wr & tos[1];
  assign flag_clr    = ctl_wr & tos[2];

  assign tx_full     = (tx_count == CW'(DEPTH));
  assign rx_empty    = (rx_count == '0);
  assign h_pop       = (tx_count != '0) & h_rd_ready;
  assign tx_push     = tx_push_req & (~tx_full | h_pop);
  assign tx_ovf_set  = tx_push_req & tx_full & ~h_pop;

  assign cpu_pop_req = rd_reg & op_sel[0];
  assign rx_pop      = cpu_pop_req & ~rx_empty;
  assign rx_unf_set  = cpu_pop_req & rx_empty;
  assign h_push      = h_wr_valid & h_wr_ready;

  assign h_rd_valid  = (tx_count != '0);
  assign h_rd_data   = tx_mem[tx_rp];
  assign h_wr_ready  = (rx_count != CW'(DEPTH));

  assign status = {tx_ovf, rx_unf, 2'b00, tx_full, rx_empty, 5'(tx_count), 5'(rx_count)};

  // par feeds tos on the same edge as rd_reg, so it is purely combinational
  always_comb begin
    par = '0;
    if (rst && rd_reg) begin
      if (op_sel[0]) begin
        par = rx_empty ? '0 : rx_mem[rx_rp];
      end else if (op_sel[1]) begin
        par = status;
      end
    end
  end

  // TX pointer/count next state; flush wins over any same-cycle push/pop
  always_comb begin
    tx_wp_nxt    = tx_wp;
    tx_rp_nxt    = tx_rp;
    tx_count_nxt = tx_count;
    if (tx_flush) begin
      tx_wp_nxt    = '0;
      tx_rp_nxt    = '0;
      tx_count_nxt = '0;
    end else begin
      if (tx_push) tx_wp_nxt = tx_wp + AW'(1);
      if (h_pop)   tx_rp_nxt = tx_rp + AW'(1);
      case ({tx_push, h_pop})
        2'b10:   tx_count_nxt = tx_count + CW'(1);
        2'b01:   tx_count_nxt = tx_count - CW'(1);
        default: tx_count_nxt = tx_count;
      endcase
    end
  end

  // RX pointer/count next state
  always_comb begin
    rx_wp_nxt    = rx_wp;
    rx_rp_nxt    = rx_rp;
    rx_count_nxt = rx_count;
    if (rx_flush) begin
      rx_wp_nxt    = '0;
      rx_rp_nxt    = '0;
      rx_count_nxt = '0;
    end else begin
      if (h_push) rx_wp_nxt = rx_wp + AW'(1);
      if (rx_pop) rx_rp_nxt = rx_rp + AW'(1);
      case ({h_push, rx_pop})
        2'b10:   rx_count_nxt = rx_count + CW'(1);
        2'b01:   rx_count_nxt = rx_count - CW'(1);
        default: rx_count_nxt = rx_count;
      endcase
    end
  end

  // A new error event outranks a same-cycle clear
  always_comb begin
    tx_ovf_nxt = tx_ovf_set | (tx_ovf & ~flag_clr);
    rx_unf_nxt = rx_unf_set | (rx_unf & ~flag_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
      tx_ovf   <= 1'b0;
      rx_unf   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      tx_wp    <= tx_wp_nxt;
      tx_rp    <= tx_rp_nxt;
      tx_count <= tx_count_nxt;
      rx_wp    <= rx_wp_nxt;
      rx_rp    <= rx_rp_nxt;
      rx_count <= rx_count_nxt;
      tx_ovf   <= tx_ovf_nxt;
      rx_unf   <= rx_unf_nxt;
      irq      <= (tx_count_nxt != '0);
    end
  end

  // Storage carries no reset; validity is tracked by the counts
  always_ff @(posedge clk) begin
    if (tx_push && !tx_flush) tx_mem[tx_wp] <= tos;
    if (h_push && !rx_flush)  rx_mem[rx_wp] <= h_wr_data;
  end

endmodule

// File: tb/tb_cpu_host_mbox.sv
// Self-checking bench for cpu_host_mbox: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_cpu_host_mbox;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_reg, rd_reg;
  logic [10:0] op_sel;
  logic [15:0] tos;
  logic [15:0] par;
  logic        h_rd_valid;
  logic [15:0] h_rd_data;
  logic        h_rd_ready;
  logic        h_wr_valid;
  logic [15:0] h_wr_data;
  logic        h_wr_ready;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic        m_ovf, m_unf;

  // outputs sampled during the last cycle
  logic [15:0] s_par, s_hrd;
  logic        s_hrv, s_hwr, s_irq;

  always #5 clk = ~clk;

  cpu_host_mbox #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_reg(wr_reg), .rd_reg(rd_reg), .op_sel(op_sel), .tos(tos),
    .par(par), .h_rd_valid(h_rd_valid), .h_rd_data(h_rd_data), .h_rd_ready(h_rd_ready),
    .h_wr_valid(h_wr_valid), .h_wr_data(h_wr_data), .h_wr_ready(h_wr_ready), .irq(irq)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [10:0] op;
    logic [15:0] tosv;
    logic        hrr;
    logic        hwv;
    logic [15:0] hwd;
    logic [15:0] e_par;
    logic        e_hrv;
    logic [15:0] e_hrd;
    logic        e_hwr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%04h required=0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_status();
    return {m_ovf, m_unf, 2'b00, 1'(tx_q.size() == DEPTH), 1'(rx_q.size() == 0),
            5'(tx_q.size()), 5'(rx_q.size())};
  endfunction

  function automatic logic [15:0] m_par(input logic rd, input logic [10:0] op);
    if (rd && op[0]) return (rx_q.size() == 0) ? 16'h0 : rx_q[0];
    if (rd && op[1]) return m_status();
    return 16'h0;
  endfunction

  // Model one clock edge from the rules: queues, not pointers
  task automatic m_step(input logic wr, input logic rd, input logic [10:0] op,
                        input logic [15:0] tv, input logic hrr, input logic hwv,
                        input logic [15:0] hwd);
    bit tx_full_b, hpop, hpush, ovf_set, unf_set, clr;
    tx_full_b = (tx_q.size() == DEPTH);
    hpop  = (tx_q.size() != 0) && hrr;
    hpush = hwv && (rx_q.size() != DEPTH);
    ovf_set = 0;
    unf_set = 0;
    clr = wr && op[1] && tv[2];
    if (hpop) void'(tx_q.pop_front());
    if (wr && op[0]) begin
      if (!tx_full_b || hpop) tx_q.push_back(tv);
      else ovf_set = 1;
    end
    if (rd && op[0]) begin
      if (rx_q.size() == 0) unf_set = 1;
      else void'(rx_q.pop_front());
    end
    if (hpush) rx_q.push_back(hwd);
    if (wr && op[1] && tv[0]) tx_q.delete();
    if (wr && op[1] && tv[1]) rx_q.delete();
    m_ovf = ovf_set || (m_ovf && !clr);
    m_unf = unf_set || (m_unf && !clr);
  endtask

  // Drive one cycle, compare all outputs with the model mid-cycle, then advance
  task automatic do_cycle(input logic wr, input logic rd, input logic [10:0] op,
                          input logic [15:0] tv, input logic hrr, input logic hwv,
                          input logic [15:0] hwd);
    wr_reg = wr; rd_reg = rd; op_sel = op; tos = tv;
    h_rd_ready = hrr; h_wr_valid = hwv; h_wr_data = hwd;
    @(negedge clk);
    s_par = par; s_hrv = h_rd_valid; s_hrd = h_rd_data; s_hwr = h_wr_ready; s_irq = irq;
    chk("par", s_par, m_par(rd, op));
    chk("h_rd_valid", 16'(s_hrv), 16'(tx_q.size() != 0));
    if (tx_q.size() != 0) chk("h_rd_data", s_hrd, tx_q[0]);
    chk("h_wr_ready", 16'(s_hwr), 16'(rx_q.size() != DEPTH));
    chk("irq", 16'(s_irq), 16'(tx_q.size() != 0));
    m_step(wr, rd, op, tv, hrr, hwv, hwd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    do_cycle(0, 0, 11'h0, 16'h0, 0, 0, 16'h0);
  endtask

  task automatic read_status(input string name, input logic [15:0] exp);
    do_cycle(0, 1, 11'h002, 16'h0, 0, 0, 16'h0);
    chk(name, s_par, exp);
  endtask

  task automatic m_reset();
    tx_q.delete();
    rx_q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  initial begin
    rst = 1'b0;
    wr_reg = 0; rd_reg = 1; op_sel = 11'h002; tos = 0;
    h_rd_ready = 0; h_wr_valid = 0; h_wr_data = 0;
    m_reset();
    #12;
    chk("rst_par", par, 16'h0);
    chk("rst_h_rd_valid", 16'(h_rd_valid), 16'h0);
    chk("rst_h_wr_ready", 16'(h_wr_ready), 16'h1);
    chk("rst_irq", 16'(irq), 16'h0);
    rd_reg = 0; op_sel = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: push/pop TX, then RX read, underflow, status, clear
    vecs[0]  = '{1, 0, 11'h001, 16'h1234, 0, 0, 16'h0,    16'h0000, 0, 16'h0,    1};
    vecs[1]  = '{1, 0, 11'h001, 16'hABCD, 0, 0, 16'h0,    16'h0000, 1, 16'h1234, 1};
    vecs[2]  = '{0, 0, 11'h000, 16'h0,    1, 0, 16'h0,    16'h0000, 1, 16'h1234, 1};
    vecs[3]  = '{0, 0, 11'h000, 16'h0,    1, 0, 16'h0,    16'h0000, 1, 16'hABCD, 1};
    vecs[4]  = '{0, 0, 11'h000, 16'h0,    0, 1, 16'h0042, 16'h0000, 0, 16'h0,    1};
    vecs[5]  = '{0, 1, 11'h001, 16'h0,    0, 0, 16'h0,    16'h0042, 0, 16'h0,    1};
    vecs[6]  = '{0, 1, 11'h001, 16'h0,    0, 0, 16'h0,    16'h0000, 0, 16'h0,    1};
    vecs[7]  = '{0, 1, 11'h002, 16'h0,    0, 0, 16'h0,    16'h4400, 0, 16'h0,    1};
    vecs[8]  = '{1, 0, 11'h002, 16'h0004, 0, 0, 16'h0,    16'h0000, 0, 16'h0,    1};
    vecs[9]  = '{0, 1, 11'h002, 16'h0,    0, 0, 16'h0,    16'h0400, 0, 16'h0,    1};
    vecs[10] = '{0, 0, 11'h003, 16'h0,    0, 0, 16'h0,    16'h0000, 0, 16'h0,    1};
    vecs[11] = '{0, 1, 11'h003, 16'h0,    0, 1, 16'h7777, 16'h0000, 0, 16'h0,    1};
    for (int i = 0; i < 12; i++) begin
      do_cycle(vecs[i].wr, vecs[i].rd, vecs[i].op, vecs[i].tosv, vecs[i].hrr,
               vecs[i].hwv, vecs[i].hwd);
      chk($sformatf("vec%0d_par", i), s_par, vecs[i].e_par);
      chk($sformatf("vec%0d_hrv", i), 16'(s_hrv), 16'(vecs[i].e_hrv));
      chk($sformatf("vec%0d_irq", i), 16'(s_irq), 16'(vecs[i].e_hrv));
      if (vecs[i].e_hrv) chk($sformatf("vec%0d_hrd", i), s_hrd, vecs[i].e_hrd);
      chk($sformatf("vec%0d_hwr", i), 16'(s_hwr), 16'(vecs[i].e_hwr));
    end
    do_cycle(1, 0, 11'h002, 16'h0006, 0, 0, 16'h0);
    read_status("clean_status", 16'h0400);

    // Fill TX, overflow push, clear flag, then full push with host pop
    for (int i = 0; i < DEPTH; i++) do_cycle(1, 0, 11'h001, 16'h0100 + 16'(i), 0, 0, 16'h0);
    do_cycle(1, 0, 11'h001, 16'hDEAD, 0, 0, 16'h0);
    read_status("ovf_status", 16'h8E00);
    do_cycle(1, 0, 11'h002, 16'h0004, 0, 0, 16'h0);
    read_status("ovf_cleared", 16'h0E00);
    do_cycle(1, 0, 11'h001, 16'hBEEF, 1, 0, 16'h0);
    read_status("full_push_pop", 16'h0E00);
    do_cycle(0, 0, 11'h0, 16'h0, 1, 0, 16'h0);
    chk("order_first", s_hrd, 16'h0101);
    for (int i = 0; i < DEPTH - 2; i++) idle_pop();
    do_cycle(0, 0, 11'h0, 16'h0, 1, 0, 16'h0);
    chk("order_last", s_hrd, 16'hBEEF);
    read_status("tx_drained", 16'h0400);

    // RX flush beats a same-cycle host write
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 11'h0, 16'h0, 0, 1, 16'h0A00 + 16'(i));
    read_status("rx_three", 16'h0003);
    do_cycle(1, 0, 11'h002, 16'h0002, 0, 1, 16'h0BAD);
    read_status("rx_flushed", 16'h0400);
    chk("rx_flushed_hwr", 16'(s_hwr), 16'h1);

    // Asynchronous reset with TX holding 5 words
    for (int i = 0; i < 5; i++) do_cycle(1, 0, 11'h001, 16'h0050 + 16'(i), 0, 0, 16'h0);
    wr_reg = 0; rd_reg = 1; op_sel = 11'h002; h_rd_ready = 0; h_wr_valid = 0;
    rst = 1'b0;
    #2;
    chk("amid_irq", 16'(irq), 16'h0);
    chk("amid_h_rd_valid", 16'(h_rd_valid), 16'h0);
    chk("amid_h_wr_ready", 16'(h_wr_ready), 16'h1);
    chk("amid_par", par, 16'h0);
    rst = 1'b1;
    m_reset();
    do_cycle(1, 0, 11'h001, 16'h0001, 0, 0, 16'h0);
    do_cycle(0, 0, 11'h0, 16'h0, 1, 0, 16'h0);
    chk("post_rst_word", s_hrd, 16'h0001);
    idle();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [10:0] op;
      logic        w, r;
      op = 11'($urandom);
      op[0] = 1'($urandom_range(0, 1));
      op[1] = ($urandom_range(0, 9) == 0);
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      do_cycle(w, r, op, 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic idle_pop();
    do_cycle(0, 0, 11'h0, 16'h0, 1, 0, 16'h0);
  endtask

endmodule
